// File: rtl/decade_count_ctrl_if.sv
// Snapshot read port of decade_count_ctrl: valid/ready handshake plus a sticky overwrite flag.
interface decade_count_ctrl_if #(
    parameter int DIGITS = 2
);
    logic                  rd_valid;
    logic                  rd_ready;
    logic [4*DIGITS-1:0]   rd_data;
    logic                  rd_ovf;

    modport master (output rd_valid, output rd_data, output rd_ovf, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input rd_ovf, output rd_ready);
endinterface

// File: rtl/decade_count_ctrl.sv
// Run-control sequencer for a cascaded BCD count chain with terminal count and snapshot port.
// Optional feature macro: DECADE_AUTO_RELOAD_EN (wrap to zero at terminal count instead of stopping).
module decade_count_ctrl #(
    parameter int DIGITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 clear,
    input  logic                 tick_en,
    input  logic [4*DIGITS-1:0]  tc_bcd,
    output logic [4*DIGITS-1:0]  count_out,
    output logic [1:0]           state,
    output logic                 done,
    output logic                 cfg_err,
    decade_count_ctrl_if.master  rd
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   tc_q, tc_d;
    logic           done_q, done_d;
    logic           cfg_err_q, cfg_err_d;
    logic           rd_valid_q, rd_valid_d;
    logic [W-1:0]   rd_data_q, rd_data_d;
    logic           rd_ovf_q, rd_ovf_d;
    logic           cap_s;
    logic [W-1:0]   cap_val_s;
    logic [W-1:0]   cnt_inc_s;
`ifdef DECADE_AUTO_RELOAD_EN
    logic [W-1:0]   reload_nxt_s;
`endif

    // Cascaded decade increment: a digit advances only when every lower digit wraps from 9.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (v[4*k +: 4] == 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[4*k +: 4] = v[4*k +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    // Next-state: command decode (clear > stop > start), counting, terminal event, snapshot port.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        tc_d      = tc_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        cap_s     = 1'b0;
        cap_val_s = count_q;
        cnt_inc_s = bcd_inc(count_q);
`ifdef DECADE_AUTO_RELOAD_EN
        reload_nxt_s = (count_q == tc_q) ? {W{1'b0}} : cnt_inc_s;
`endif
        if (clear) begin
            state_d = ST_IDLE;
            count_d = {W{1'b0}};
        end else if (stop) begin
            if (state_q == ST_RUN) begin
                state_d   = ST_HOLD;
                cap_s     = 1'b1;
                cap_val_s = count_q;
            end else begin
                state_d = state_q;
            end
        end else if (start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            if (bcd_valid(tc_bcd)) begin
                tc_d    = tc_bcd;
                count_d = {W{1'b0}};
                state_d = ST_RUN;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (start && state_q == ST_HOLD) begin
            state_d = ST_RUN;
        end else if (state_q == ST_RUN) begin
`ifdef DECADE_AUTO_RELOAD_EN
            if (tick_en) begin
                count_d = reload_nxt_s;
                if (reload_nxt_s == tc_q) begin
                    done_d    = 1'b1;
                    cap_s     = 1'b1;
                    cap_val_s = tc_q;
                end else begin
                    done_d = 1'b0;
                end
            end else begin
                count_d = count_q;
            end
`else
            // A zero terminal count is already met on entry, so it fires without a tick.
            if (count_q == tc_q) begin
                done_d    = 1'b1;
                state_d   = ST_DONE;
                cap_s     = 1'b1;
                cap_val_s = tc_q;
            end else if (tick_en) begin
                count_d = cnt_inc_s;
                if (cnt_inc_s == tc_q) begin
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                    cap_s     = 1'b1;
                    cap_val_s = tc_q;
                end else begin
                    state_d = ST_RUN;
                end
            end else begin
                count_d = count_q;
            end
`endif
        end else begin
            state_d = state_q;
        end

        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_ovf_d   = clear ? 1'b0 : rd_ovf_q;
        // A capture coinciding with acceptance replaces the data without flagging overwrite.
        if (cap_s) begin
            rd_data_d  = cap_val_s;
            rd_valid_d = 1'b1;
            if (rd_valid_q && !rd.rd_ready) begin
                rd_ovf_d = 1'b1;
            end else begin
                rd_ovf_d = rd_ovf_d;
            end
        end else if (rd_valid_q && rd.rd_ready) begin
            rd_valid_d = 1'b0;
        end else begin
            rd_valid_d = rd_valid_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            count_q    <= {W{1'b0}};
            tc_q       <= {W{1'b0}};
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= {W{1'b0}};
            rd_ovf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            tc_q       <= tc_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_ovf_q   <= rd_ovf_d;
        end
    end

    assign count_out   = count_q;
    assign state       = state_q;
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;
    assign rd.rd_valid = rd_valid_q;
    assign rd.rd_data  = rd_data_q;
    assign rd.rd_ovf   = rd_ovf_q;

endmodule

// File: tb/tb_decade_count_ctrl.sv
// Scoreboard bench for decade_count_ctrl: a decimal reference model queues expected outputs per cycle.
module tb_decade_count_ctrl;
    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;
    localparam int MODV   = 100;

    logic         clk = 1'b0;
    logic         reset, start, stop, clear, tick_en;
    logic [W-1:0] tc_bcd;
    logic [W-1:0] count_out;
    logic [1:0]   state;
    logic         done, cfg_err;

    typedef struct {
        logic [W-1:0] count;
        logic [1:0]   st;
        logic         done;
        logic         cfg_err;
        logic         valid;
        logic [W-1:0] data;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_state, m_cnt, m_tc, m_data;
    logic m_valid, m_ovf, m_done, m_cfg;
    int   done_seen;

    decade_count_ctrl_if #(.DIGITS(DIGITS)) rd_if ();

    decade_count_ctrl #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .tick_en   (tick_en),
        .tc_bcd    (tc_bcd),
        .count_out (count_out),
        .state     (state),
        .done      (done),
        .cfg_err   (cfg_err),
        .rd        (rd_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           x;
        x = v;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int to_int(input logic [W-1:0] b);
        int r;
        int p;
        r = 0;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            r = r + int'(b[4*k +: 4]) * p;
            p = p * 10;
        end
        return r;
    endfunction

    function automatic bit tc_ok(input logic [W-1:0] b);
        bit ok;
        ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) if (b[4*k +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    // Reference model: advance one clock using the currently driven inputs, push expected outputs.
    task automatic model_step();
        exp_t e;
        bit   cap;
        int   capv;
        cap = 1'b0;
        capv = 0;
        m_done = 1'b0;
        m_cfg = 1'b0;
        if (!reset) begin
            m_state = 0; m_cnt = 0; m_tc = 0; m_data = 0; m_valid = 1'b0; m_ovf = 1'b0;
        end else begin
            if (clear) begin
                m_state = 0; m_cnt = 0; m_ovf = 1'b0;
            end else if (stop) begin
                if (m_state == 1) begin m_state = 2; cap = 1'b1; capv = m_cnt; end
            end else if (start && (m_state == 0 || m_state == 3)) begin
                if (tc_ok(tc_bcd)) begin m_tc = to_int(tc_bcd); m_cnt = 0; m_state = 1; end
                else m_cfg = 1'b1;
            end else if (start && m_state == 2) begin
                m_state = 1;
            end else if (m_state == 1) begin
`ifdef DECADE_AUTO_RELOAD_EN
                if (tick_en) begin
                    m_cnt = (m_cnt == m_tc) ? 0 : m_cnt + 1;
                    if (m_cnt == m_tc) begin m_done = 1'b1; cap = 1'b1; capv = m_tc; end
                end
`else
                if (m_cnt == m_tc) begin
                    m_done = 1'b1; m_state = 3; cap = 1'b1; capv = m_tc;
                end else if (tick_en) begin
                    m_cnt = (m_cnt + 1) % MODV;
                    if (m_cnt == m_tc) begin m_done = 1'b1; m_state = 3; cap = 1'b1; capv = m_tc; end
                end
`endif
            end
            if (cap) begin
                if (m_valid && !rd_if.rd_ready) m_ovf = 1'b1;
                m_valid = 1'b1;
                m_data = capv;
            end else if (m_valid && rd_if.rd_ready) begin
                m_valid = 1'b0;
            end
        end
        e.count = to_bcd(m_cnt);
        e.st = 2'(m_state);
        e.done = m_done;
        e.cfg_err = m_cfg;
        e.valid = m_valid;
        e.data = to_bcd(m_data);
        e.ovf = m_ovf;
        sb_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("count", 32'(count_out), 32'(e.count));
            chk("state", 32'(state), 32'(e.st));
            chk("done", 32'(done), 32'(e.done));
            chk("cfg_err", 32'(cfg_err), 32'(e.cfg_err));
            chk("rd_valid", 32'(rd_if.rd_valid), 32'(e.valid));
            chk("rd_data", 32'(rd_if.rd_data), 32'(e.data));
            chk("rd_ovf", 32'(rd_if.rd_ovf), 32'(e.ovf));
        end
    endtask

    task automatic step(input logic s, input logic p, input logic c, input logic t, input logic [W-1:0] tc);
        start = s; stop = p; clear = c; tick_en = t; tc_bcd = tc;
        model_step();
        @(posedge clk);
        #1;
        compare_out();
        if (done) done_seen++;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; tick_en = 1'b0;
        tc_bcd = '0; rd_if.rd_ready = 1'b1; done_seen = 0;
        m_state = 0; m_cnt = 0; m_tc = 0; m_data = 0; m_valid = 1'b0; m_ovf = 1'b0;
        m_done = 1'b0; m_cfg = 1'b0;
        @(posedge clk); #1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h09);
        chk("rst_count", 32'(count_out), 32'h0);
        chk("rst_state", 32'(state), 32'h0);
        reset = 1'b1;

        // Count 00..09 with terminal stop.
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h09);
        chk("t1_start_cnt", 32'(count_out), 32'h00);
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 8'h09);
            chk("t1_cnt", 32'(count_out), 32'(to_bcd(i)));
        end
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_state", 32'(state), 32'h3);
        chk("t1_rd_data", 32'(rd_if.rd_data), 32'h09);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h09);
        chk("t1_hold09", 32'(count_out), 32'h09);

        // Pause at 15, resume, terminate at 23.
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h23);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h23);
        chk("t2_cnt15", 32'(count_out), 32'h15);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h23);
        chk("t2_hold", 32'(state), 32'h2);
        chk("t2_snap", 32'(rd_if.rd_data), 32'h15);
        chk("t2_nocount", 32'(count_out), 32'h15);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h23);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h99);
        chk("t2_resume_cnt", 32'(count_out), 32'h15);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h99);
        chk("t2_cnt16", 32'(count_out), 32'h16);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h99);
        chk("t2_done23", 32'(done), 32'h1);
        chk("t2_cnt23", 32'(count_out), 32'h23);

        // Invalid terminal count is rejected.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h1A);
        chk("t3_cfg_err", 32'(cfg_err), 32'h1);
        chk("t3_idle", 32'(state), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h1A);
        chk("t3_cfg_pulse", 32'(cfg_err), 32'h0);

        // Overwrite of an unaccepted snapshot.
        rd_if.rd_ready = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h05);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h05);
        chk("t4_snap1", 32'(rd_if.rd_data), 32'h02);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h05);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
        chk("t4_ovf", 32'(rd_if.rd_ovf), 32'h1);
        chk("t4_snap2", 32'(rd_if.rd_data), 32'h05);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h05);
        chk("t4_clr_ovf", 32'(rd_if.rd_ovf), 32'h0);
        chk("t4_clr_valid", 32'(rd_if.rd_valid), 32'h1);
        rd_if.rd_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h05);
        chk("t4_accept", 32'(rd_if.rd_valid), 32'h0);

        // Zero terminal count.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
`ifndef DECADE_AUTO_RELOAD_EN
        chk("t5_tc0_done", 32'(done), 32'h1);
`endif
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Full-range run: carry 09->10 and wrap or stop at 99.
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h99);
        done_seen = 0;
        for (int i = 1; i <= 210; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 8'h99);
            if (i == 10) chk("t6_carry", 32'(count_out), 32'h10);
        end
`ifdef DECADE_AUTO_RELOAD_EN
        chk("t6_done_cnt", 32'(done_seen), 32'd2);
        chk("t6_run", 32'(state), 32'h1);
        chk("t6_wrap", 32'(count_out), 32'h10);
`else
        chk("t6_done_cnt", 32'(done_seen), 32'd1);
        chk("t6_stop", 32'(state), 32'h3);
        chk("t6_hold99", 32'(count_out), 32'h99);
`endif

        // Reset in the middle of a run.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h99);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h99);
        for (int i = 0; i < 47; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h99);
        chk("t7_cnt47", 32'(count_out), 32'h47);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h99);
        chk("t7_rst_cnt", 32'(count_out), 32'h0);
        chk("t7_rst_state", 32'(state), 32'h0);
        chk("t7_rst_valid", 32'(rd_if.rd_valid), 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h99);
        chk("t7_no_resume", 32'(count_out), 32'h0);

        // Randomised command mix checked against the model.
        for (int i = 0; i < 600; i++) begin
            logic [W-1:0] tcr;
            tcr = to_bcd($urandom_range(0, 30));
            if ($urandom_range(0, 15) == 0) tcr[3:0] = 4'hB;
            reset = ($urandom_range(0, 199) != 0);
            rd_if.rd_ready = ($urandom_range(0, 2) != 0);
            step(($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), tcr);
        end

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decade_count_ctrl.md
# decade_count_ctrl

Run-control sequencer for a synchronous, cascaded BCD (decade) count chain of DIGITS digits. It accepts start/stop/clear commands and a programmable terminal count, and advances the chain on qualified ticks. It reports terminal events and hands captured count snapshots to a consumer over a valid/ready port. It sits between the system control logic and the decade-counter datapath; the chain it drives replaces free-running ripple counting.

## Interface
- DIGITS, 2, number of BCD digits in the chain (1..4)
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  start/resume command (level sampled each cycle)
- stop  in  1  pause command
- clear  in  1  abort and zero command
- tick_en  in  1  count strobe; one increment per cycle high while RUN
- tc_bcd  in  4*DIGITS  terminal count, BCD, digit 0 in bits [3:0]
- count_out  out  4*DIGITS  live BCD count
- state  out  2  00 IDLE, 01 RUN, 10 HOLD, 11 DONE
- done  out  1  one-cycle terminal-event pulse
- cfg_err  out  1  one-cycle pulse: start rejected, tc_bcd has a digit >9
- rd_valid  out  1  snapshot available
- rd_ready  in  1  consumer accepts snapshot
- rd_data  out  4*DIGITS  snapshot value
- rd_ovf  out  1  sticky: snapshot overwritten before acceptance

## Operation
- Reset (reset=0 at a clock edge): state=IDLE, count_out=0, done=0, cfg_err=0, rd_valid=0, rd_data=0, rd_ovf=0, tc_q=0.
- Command priority: clear > stop > start. Other commands in the same cycle are ignored.
- clear (any state): state→IDLE, count→0, rd_ovf→0. Snapshot register and rd_valid are unchanged.
- start in IDLE or DONE: if every digit of tc_bcd ≤9, sample tc_bcd into tc_q, set count→0, state→RUN. Otherwise cfg_err pulses and the state is unchanged.
- start in HOLD: state→RUN. Count is kept and tc_q is not resampled. start in RUN has no effect.
- stop in RUN: state→HOLD and a snapshot is captured. stop in any other state has no effect.
- Increment: in RUN with tick_en=1, digit k increments when all lower digits equal 9. A digit at 9 wraps to 0.
- Terminal event: a tick that makes count equal tc_q sets done=1 for that result cycle and captures a snapshot of tc_q.
  - Without reload: state→DONE and the count holds at tc_q.
  - tc_q=0 without reload: the terminal event fires on the first RUN cycle, whether or not a tick occurs.
- Snapshot capture: rd_data←value, rd_valid←1. If rd_valid=1 and rd_ready=0 at capture time, rd_ovf←1 and rd_data is overwritten.
- Handshake: transfer completes on a cycle with rd_valid=1 and rd_ready=1; rd_valid→0 next cycle, unless a capture occurs in the same cycle, in which case rd_valid stays 1 with the new data and rd_ovf is not set.
- A tick in the same cycle as stop or clear is not counted.

## Timing
- All outputs are registered. Commands take effect at the next edge.
- The first countable tick is in the first cycle with state=RUN; a tick coincident with start is ignored.
- done, count_out=tc_q, and rd_valid rise in the same cycle, one edge after the terminal tick.
- Throughput: one increment per cycle. Snapshot latency is one edge.

## Configuration
- DECADE_AUTO_RELOAD_EN defined: a RUN tick while count=tc_q sets count→0, and the state stays RUN.
  - The count cycles 0..tc_q with period tc_q+1 ticks, and done pulses each time the count becomes tc_q.
  - tc_q=0: count stays 0 and done pulses on every tick.
  - The DONE state is unreachable.
- Undefined: behaviour is the terminal-stop behaviour above.

## Test plan
- Reset with DIGITS=2, then start with tc=0x09 and tick_en=1 continuously → count 00..09 on consecutive cycles; done and DONE state in the cycle count=09; rd_data=0x09.
- tc=0x23, ticks to 0x15, stop → HOLD, rd_data=0x15. Then start → resumes 0x16, and the terminal event occurs at 0x23.
- start with tc_bcd=0x1A → cfg_err pulses once, state stays IDLE, count stays 00.
- Hold rd_ready=0, cause two captures (stop, start, terminal) → rd_ovf=1 and rd_data is the second value. clear → rd_ovf=0 and rd_valid stays 1.
- DECADE_AUTO_RELOAD_EN with tc=0x99 → count wraps 99→00, done pulses every 100 ticks, state stays RUN; the 09→10 carry is verified.
- Assert reset=0 mid-RUN at count 0x47 → at the next edge all outputs are at their reset values; the count does not resume.
